// File: rtl/adder_pkg.sv
// Shared types and constants for the adder result path.
package adder_pkg;

    localparam int unsigned WIDTH = 32;

    // One captured adder result with its precomputed flags.
    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
        logic             zero;
        logic             neg;
    } adder_result_t;

    // Saturation targets for positive and negative signed overflow.
    localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    // Occupancy of the 2-entry skid buffer.
    typedef enum logic [1:0] {
        StEmpty,
        StOne,
        StTwo
    } occ_e;

endpackage

// File: rtl/adder_skid_buf.sv
// Two-entry valid/ready buffer over adder_result_t.
// The output register and the ready flag are both registered. This keeps in_ready
// independent of out_ready. The second entry (skid) absorbs the one result that
// arrives in the cycle in which the downstream stalls.
module adder_skid_buf
    import adder_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  adder_result_t in_data_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output adder_result_t out_data_o
);

    occ_e          state_q;
    adder_result_t out_q;
    adder_result_t skid_q;
    logic          in_ready_q;
    logic          out_valid_q;

    logic push;
    logic pop;

    assign push = in_valid_i & in_ready_q;
    assign pop  = out_valid_q & out_ready_i;

    // Occupancy FSM: moves data between input, skid and output registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= StEmpty;
            out_q       <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (push) begin
                        out_q       <= in_data_i;
                        out_valid_q <= 1'b1;
                        state_q     <= StOne;
                    end
                end
                StOne: begin
                    if (push && !pop) begin
                        skid_q     <= in_data_i;
                        in_ready_q <= 1'b0;
                        state_q    <= StTwo;
                    end else if (push && pop) begin
                        out_q <= in_data_i;
                    end else if (pop) begin
                        out_valid_q <= 1'b0;
                        state_q     <= StEmpty;
                    end
                end
                StTwo: begin
                    // in_ready is low here, so only a pop can occur.
                    if (pop) begin
                        out_q      <= skid_q;
                        in_ready_q <= 1'b1;
                        state_q    <= StOne;
                    end
                end
                default: begin
                    state_q     <= StEmpty;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_q;

endmodule

// File: rtl/adder_result_stage.sv
// Registered consumer stage for the ripple adder result.
// This stage forms the zero and neg flags, and optionally saturates the sum.
// It buffers the result through a 2-entry skid buffer.
// It also counts signed overflows with a saturating counter.
// Build option: define ADDER_RESULT_SAT_EN to clamp the sum to SAT_POS or SAT_NEG on overflow.
module adder_result_stage
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH     = adder_pkg::WIDTH,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_sum,
    input  logic                 in_cout,
    input  logic                 in_ovf,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_sum,
    output logic                 out_cout,
    output logic                 out_ovf,
    output logic                 out_zero,
    output logic                 out_neg,
    output logic [CNT_WIDTH-1:0] ovf_count,
    input  logic                 ovf_clr
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    adder_result_t        in_entry;
    adder_result_t        out_entry;
    logic [WIDTH-1:0]     stored_sum;
    logic                 ovf_hit;
    logic [CNT_WIDTH-1:0] cnt_q;

    // Form the stored value and its flags before capture.
    always_comb begin
        stored_sum = in_sum;
`ifdef ADDER_RESULT_SAT_EN
        // A set sign bit on overflow means a positive sum wrapped negative.
        if (in_ovf) begin
            stored_sum = in_sum[WIDTH-1] ? SAT_POS : SAT_NEG;
        end
`endif
        in_entry.sum  = stored_sum;
        in_entry.cout = in_cout;
        in_entry.ovf  = in_ovf;
        in_entry.zero = (stored_sum == '0);
        in_entry.neg  = stored_sum[WIDTH-1];
    end

    adder_skid_buf u_skid (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_entry),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_entry)
    );

    assign ovf_hit = in_valid & in_ready & in_ovf;

    // Saturating overflow counter. A clear on the same edge as a hit restarts the count at one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (ovf_clr) begin
            cnt_q <= ovf_hit ? CNT_ONE : '0;
        end else if (ovf_hit && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + CNT_ONE;
        end
    end

    assign out_sum   = out_entry.sum;
    assign out_cout  = out_entry.cout;
    assign out_ovf   = out_entry.ovf;
    assign out_zero  = out_entry.zero;
    assign out_neg   = out_entry.neg;
    assign ovf_count = cnt_q;

endmodule

// File: tb/tb_adder_result_stage.sv
// Scoreboard bench for adder_result_stage with a 2-bit overflow counter.
module tb_adder_result_stage;

    localparam int unsigned CNT_W   = 2;
    localparam int          CNT_TOP = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        logic        neg;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_sum = '0;
    logic             in_cout = 1'b0;
    logic             in_ovf = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [31:0]      out_sum;
    logic             out_cout;
    logic             out_ovf;
    logic             out_zero;
    logic             out_neg;
    logic [CNT_W-1:0] ovf_count;
    logic             ovf_clr = 1'b0;

    int   total = 0;
    int   bad = 0;
    bit   mon_en = 1'b0;
    bit   rand_mode = 1'b0;
    bit   acc_last = 1'b0;
    bit   m_acc;
    bit   m_pop;
    int   m_cnt = 0;
    exp_t q[$];

    adder_result_stage #(
        .WIDTH     (32),
        .CNT_WIDTH (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sum    (in_sum),
        .in_cout   (in_cout),
        .in_ovf    (in_ovf),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .out_zero  (out_zero),
        .out_neg   (out_neg),
        .ovf_count (ovf_count),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected stored entry, from the arithmetic meaning of the result.
    function automatic exp_t mk(input logic [31:0] s, input logic c, input logic o);
        exp_t        e;
        logic [31:0] v;
        v = s;
`ifdef ADDER_RESULT_SAT_EN
        if (o) v = s[31] ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
        e.sum  = v;
        e.cout = c;
        e.ovf  = o;
        e.zero = (v == 32'd0);
        e.neg  = (v >= 32'h8000_0000);
        return e;
    endfunction

    // Reference model: this block tracks the items held in the stage and the overflow count.
    always @(posedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_cnt    = 0;
            acc_last = 1'b0;
        end else begin
            m_acc = in_valid && (q.size() < 2);
            m_pop = (q.size() > 0) && out_ready;
            if (m_pop) void'(q.pop_front());
            if (m_acc) q.push_back(mk(in_sum, in_cout, in_ovf));
            if (ovf_clr) m_cnt = (m_acc && in_ovf) ? 1 : 0;
            else if (m_acc && in_ovf && m_cnt < CNT_TOP) m_cnt++;
            acc_last = m_acc;
        end
    end

    // Monitor: this block compares the presented outputs with the head of the scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
            chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
            chk("ovf_count", 64'(ovf_count), 64'(m_cnt));
            if (q.size() > 0 && out_valid === 1'b1) begin
                chk("out_sum", 64'(out_sum), 64'(q[0].sum));
                chk("out_cout", 64'(out_cout), 64'(q[0].cout));
                chk("out_ovf", 64'(out_ovf), 64'(q[0].ovf));
                chk("out_zero", 64'(out_zero), 64'(q[0].zero));
                chk("out_neg", 64'(out_neg), 64'(q[0].neg));
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
        if (rand_mode) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Hold one result on the input until it is accepted (bounded).
    task automatic send(input logic [31:0] s, input logic c, input logic o, input logic clr);
        int n;
        in_valid = 1'b1;
        in_sum   = s;
        in_cout  = c;
        in_ovf   = o;
        ovf_clr  = clr;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!acc_last && n < 50);
        if (!acc_last) begin
            total++;
            bad++;
            $display("FAIL accept_timeout got=stalled want=accepted sum=%0h", s);
        end
        in_valid = 1'b0;
        ovf_clr  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rs;
        int          sel;

        rst_n = 1'b0;
        idle(2);
        mon_en = 1'b1;
        rst_n  = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_sum", 64'(out_sum), 64'd0);
        chk("rst_flags", 64'({out_cout, out_ovf, out_zero, out_neg}), 64'd0);
        chk("rst_count", 64'(ovf_count), 64'd0);
        @(posedge clk);
        #1;

        // Basic captures and flags.
        out_ready = 1'b1;
        send(32'h0000_0005, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("t1_sum", 64'(out_sum), 64'd5);
        chk("t1_zero_neg", 64'({out_zero, out_neg}), 64'd0);
        send(32'h0000_0000, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("t2_zero_cout", 64'({out_zero, out_cout}), 64'b11);
        send(32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("t2_neg", 64'(out_neg), 64'd1);
        idle(2);

        // Stall: fill the skid, then drain in order.
        out_ready = 1'b0;
        send(32'h0000_00AA, 1'b0, 1'b0, 1'b0);
        send(32'h0000_00BB, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("t3_ready_low", 64'(in_ready), 64'd0);
        chk("t3_hold_a", 64'(out_sum), 64'hAA);
        idle(3);
        out_ready = 1'b1;
        idle(4);

        // Overflow handling and saturating counter.
        do_reset();
        send(32'h8000_0000, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
`ifdef ADDER_RESULT_SAT_EN
        chk("t4_sum", 64'(out_sum), 64'h7FFF_FFFF);
`else
        chk("t4_sum", 64'(out_sum), 64'h8000_0000);
`endif
        chk("t4_count", 64'(ovf_count), 64'd1);
        send(32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
`ifdef ADDER_RESULT_SAT_EN
        chk("t5_sum", 64'(out_sum), 64'h8000_0000);
        chk("t5_neg", 64'(out_neg), 64'd1);
`else
        chk("t5_sum", 64'(out_sum), 64'h7FFF_FFFF);
        chk("t5_neg", 64'(out_neg), 64'd0);
`endif
        for (int i = 0; i < 3; i++) send($urandom, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("t5_count_sat", 64'(ovf_count), 64'd3);
        send(32'h1234_5678, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        chk("t5_clr_hit", 64'(ovf_count), 64'd1);
        idle(2);

        // Reset while two entries are held.
        out_ready = 1'b0;
        send(32'h0000_0011, 1'b0, 1'b1, 1'b0);
        send(32'h0000_0022, 1'b0, 1'b1, 1'b0);
        do_reset();
        @(negedge clk);
        chk("t6_out_valid", 64'(out_valid), 64'd0);
        chk("t6_in_ready", 64'(in_ready), 64'd1);
        chk("t6_count", 64'(ovf_count), 64'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        idle(4);

        // Random traffic with random back-pressure and clears.
        rand_mode = 1'b1;
        for (int i = 0; i < 400; i++) begin
            idle($urandom_range(0, 2));
            sel = $urandom_range(0, 7);
            rs  = $urandom;
            if (sel == 0) rs = 32'h0;
            else if (sel == 1) rs = 32'h7FFF_FFFF;
            else if (sel == 2) rs = 32'h8000_0000;
            send(rs, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 15) == 0));
        end
        rand_mode = 1'b0;
        out_ready = 1'b1;
        idle(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
